gate_drive_monitor: RTL

Supervisor for the complementary gate-drive pair produced by the PWM/dead-time controller. It runs on the drive-side signals (the controller's driver_1/driver_2 or their board feedback) and does four things: detects shoot-through, measures each dead-time gap, measures carrier period and high time of leg A, and detects a stalled modulator. Any fault is latched and removes `enable_out`, which gates the power-stage drivers until software clears the fault.

---
 rtl/gate_drive_monitor.sv | 261 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/gate_drive_monitor.sv
`default_nettype none
// ============================================================================
// Module      : gate_drive_monitor
// Description : Supervisor for a complementary gate-drive pair. Synchronizes
//               both legs, detects shoot-through, measures both dead-time
//               gaps, measures carrier period / leg-A high time and detects a
//               stalled modulator. Any fault is latched and removes
//               enable_out until software clears it.
// Ports       : clk_50      - 50 MHz system clock
//               rst         - synchronous active-high reset
//               drv_a_in    - leg A gate drive (asynchronous)
//               drv_b_in    - leg B gate drive (asynchronous)
//               fault_clr   - single-cycle fault clear request
//               enable_out  - 1 = power-stage drivers may switch
//               fault_shoot - latched shoot-through fault
//               fault_dead  - latched dead-time violation
//               fault_stall - latched no-edge timeout
//               dead_ab     - last A-fall to B-rise gap (cycles)
//               dead_ba     - last B-fall to A-rise gap (cycles)
//               period      - cycles between the two latest A rising edges
//               high_time   - A high duration within that period
//               meas_valid  - one-cycle strobe on period/high_time update
// Revision    : 1.0 - initial release
// ============================================================================
module gate_drive_monitor #(
  parameter int MIN_DEAD = 3,
  parameter int TIMEOUT  = 50000,
  parameter int CNT_W    = 16
) (
  input  logic             clk_50,
  input  logic             rst,
  input  logic             drv_a_in,
  input  logic             drv_b_in,
  input  logic             fault_clr,
  output logic             enable_out,
  output logic             fault_shoot,
  output logic             fault_dead,
  output logic             fault_stall,
  output logic [7:0]       dead_ab,
  output logic [7:0]       dead_ba,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid
);

  typedef enum logic [2:0] {
    ST_INIT    = 3'd0,
    ST_A_ON    = 3'd1,
    ST_DEAD_AB = 3'd2,
    ST_B_ON    = 3'd3,
    ST_DEAD_BA = 3'd4,
    ST_FAULT   = 3'd5
  } state_t;

  localparam logic [7:0]       MIN_DEAD_C = 8'(MIN_DEAD);
  // A direct swap is a zero-length gap; it is only illegal if MIN_DEAD > 0.
  localparam logic             SWAP_SHORT = (MIN_DEAD > 0);
  localparam logic [15:0]      STALL_LAST = 16'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  // --------------------------------------------------------------------------
  // Input synchronizers: s1/s2 resolve metastability, s3 is the edge reference
  // --------------------------------------------------------------------------
  logic a_s1, a_s2, a_s3;
  logic b_s1, b_s2, b_s3;

  always_ff @(posedge clk_50) begin
    if (rst) begin
      a_s1 <= 1'b0; a_s2 <= 1'b0; a_s3 <= 1'b0;
      b_s1 <= 1'b0; b_s2 <= 1'b0; b_s3 <= 1'b0;
    end else begin
      a_s1 <= drv_a_in; a_s2 <= a_s1; a_s3 <= a_s2;
      b_s1 <= drv_b_in; b_s2 <= b_s1; b_s3 <= b_s2;
    end
  end

  logic a, b;
  logic any_edge, rise_a, fall_a;
  logic clr_ok, stall_hit;

  state_t      state;
  logic [7:0]  dead_cnt;
  logic [15:0] stall_cnt;

  assign a        = a_s2;
  assign b        = b_s2;
  assign any_edge = (a ^ a_s3) | (b ^ b_s3);
  assign rise_a   = a & ~a_s3;
  assign fall_a   = ~a & a_s3;
  // A clear is honoured only while both legs are off.
  assign clr_ok   = fault_clr & ~a & ~b;
  assign stall_hit = (state != ST_FAULT) && !any_edge && (stall_cnt == STALL_LAST);

  // --------------------------------------------------------------------------
  // Supervisor FSM, fault flags, dead-time measurement and stall counter.
  // Later non-blocking assignments win, so a fault detected in the same cycle
  // as an accepted clear leaves its flag set.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_50) begin
    if (rst) begin
      state       <= ST_INIT;
      dead_cnt    <= 8'd0;
      dead_ab     <= 8'd0;
      dead_ba     <= 8'd0;
      stall_cnt   <= 16'd0;
      fault_shoot <= 1'b0;
      fault_dead  <= 1'b0;
      fault_stall <= 1'b0;
    end else begin
      if (state == ST_FAULT || any_edge) begin
        stall_cnt <= 16'd0;
      end else begin
        stall_cnt <= stall_cnt + 16'd1;
      end

      if (clr_ok) begin
        fault_shoot <= 1'b0;
        fault_dead  <= 1'b0;
        fault_stall <= 1'b0;
        stall_cnt   <= 16'd0;
        state       <= ST_INIT;
      end else if (state != ST_FAULT) begin
        if (a && b) begin
          fault_shoot <= 1'b1;
          state       <= ST_FAULT;
        end else begin
          case (state)
            ST_INIT: begin
              // Leaving INIT only synchronises to the waveform; no gap is known.
              if (a) begin
                state <= ST_A_ON;
              end else if (b) begin
                state <= ST_B_ON;
              end
            end
            ST_A_ON: begin
              if (!a && !b) begin
                state    <= ST_DEAD_AB;
                dead_cnt <= 8'd1;
              end else if (!a && b) begin
                dead_ab <= 8'd0;
                state   <= ST_B_ON;
                if (SWAP_SHORT) begin
                  fault_dead <= 1'b1;
                  state      <= ST_FAULT;
                end
              end
            end
            ST_DEAD_AB: begin
              if (b) begin
                dead_ab <= dead_cnt;
                state   <= ST_B_ON;
                if (dead_cnt < MIN_DEAD_C) begin
                  fault_dead <= 1'b1;
                  state      <= ST_FAULT;
                end
              end else if (a) begin
                state <= ST_A_ON;
              end else if (dead_cnt != 8'hFF) begin
                dead_cnt <= dead_cnt + 8'd1;
              end
            end
            ST_B_ON: begin
              if (!a && !b) begin
                state    <= ST_DEAD_BA;
                dead_cnt <= 8'd1;
              end else if (a && !b) begin
                dead_ba <= 8'd0;
                state   <= ST_A_ON;
                if (SWAP_SHORT) begin
                  fault_dead <= 1'b1;
                  state      <= ST_FAULT;
                end
              end
            end
            ST_DEAD_BA: begin
              if (a) begin
                dead_ba <= dead_cnt;
                state   <= ST_A_ON;
                if (dead_cnt < MIN_DEAD_C) begin
                  fault_dead <= 1'b1;
                  state      <= ST_FAULT;
                end
              end else if (b) begin
                state <= ST_B_ON;
              end else if (dead_cnt != 8'hFF) begin
                dead_cnt <= dead_cnt + 8'd1;
              end
            end
            default: state <= ST_INIT;
          endcase
        end
      end

      if (stall_hit) begin
        fault_stall <= 1'b1;
        state       <= ST_FAULT;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Carrier period / high-time measurement on leg A. The first rising edge
  // after reset or clear only arms the counters. Measurement is frozen while
  // faulted so the outputs keep the last good values.
  // --------------------------------------------------------------------------
  logic             armed;
  logic [CNT_W-1:0] per_cnt;
  logic [CNT_W-1:0] hi_cnt;
  logic [CNT_W-1:0] hi_cap;

  always_ff @(posedge clk_50) begin
    if (rst) begin
      armed      <= 1'b0;
      per_cnt    <= '0;
      hi_cnt     <= '0;
      hi_cap     <= '0;
      period     <= '0;
      high_time  <= '0;
      meas_valid <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      if (clr_ok) begin
        armed <= 1'b0;
      end else if (state != ST_FAULT) begin
        if (rise_a) begin
          per_cnt <= CNT_ONE;
          hi_cnt  <= CNT_ONE;
          armed   <= 1'b1;
          if (armed) begin
            period     <= per_cnt;
            high_time  <= hi_cap;
            meas_valid <= 1'b1;
          end
        end else begin
          if (per_cnt != CNT_MAX) begin
            per_cnt <= per_cnt + CNT_ONE;
          end
          if (a && hi_cnt != CNT_MAX) begin
            hi_cnt <= hi_cnt + CNT_ONE;
          end
        end
        if (fall_a) begin
          hi_cap <= hi_cnt;
        end
      end
    end
  end

  // Registered so the enable lags the fault flags by exactly one cycle.
  always_ff @(posedge clk_50) begin
    if (rst) begin
      enable_out <= 1'b0;
    end else begin
      enable_out <= ~(fault_shoot | fault_dead | fault_stall);
    end
  end

endmodule
`default_nettype wire
